// File: rtl/bin_accel_pkg.sv
// Shared constants, FSM encoding and header helper for the binary accelerator.
package bin_accel_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] TERM_WORD = 16'h00FF;

    // Matrix widths the pooling stage accepts; anything else ends the stream.
    localparam logic [DATA_W-1:0] WIDTH_8  = 16'd8;
    localparam logic [DATA_W-1:0] WIDTH_10 = 16'd10;
    localparam logic [DATA_W-1:0] WIDTH_14 = 16'd14;

    // One-hot control states.
    localparam int ST_W = 6;
    localparam logic [ST_W-1:0] ST_IDLE = 6'b000001;
    localparam logic [ST_W-1:0] ST_HDR  = 6'b000010;
    localparam logic [ST_W-1:0] ST_ROWA = 6'b000100;
    localparam logic [ST_W-1:0] ST_ROWB = 6'b001000;
    localparam logic [ST_W-1:0] ST_TERM = 6'b010000;
    localparam logic [ST_W-1:0] ST_DONE = 6'b100000;

    // Sub-steps of the header state: present address, decode data, prime first row read.
    localparam logic [1:0] HDR_ADDR   = 2'd0;
    localparam logic [1:0] HDR_DECODE = 2'd1;
    localparam logic [1:0] HDR_FILL   = 2'd2;

    function automatic logic is_legal_width(input logic [DATA_W-1:0] hdr);
        return (hdr == WIDTH_8) || (hdr == WIDTH_10) || (hdr == WIDTH_14);
    endfunction

endpackage

// File: rtl/bin_pool_row.sv
// Combinational 2x2 OR-pool of two binary rows; bits at or above W/2 are forced to 0.
module bin_pool_row
    import bin_accel_pkg::*;
(
    input  logic [DATA_W-1:0] row_a,
    input  logic [DATA_W-1:0] row_b,
    input  logic [3:0]        width,
    output logic [DATA_W-1:0] pooled
);

    logic [3:0] pool_cols;

    assign pool_cols = width >> 1;

    // Each output column ORs a 2x2 window; columns past the pooled width stay 0,
    // which also keeps source bits >= W out of the result.
    always_comb begin
        pooled = '0;
        for (int j = 0; j < DATA_W / 2; j++) begin
            if (4'(j) < pool_cols) begin
                pooled[j] = row_a[2*j] | row_a[2*j+1] | row_b[2*j] | row_b[2*j+1];
            end
        end
    end

endmodule

// File: rtl/bin_maxpool_stage.sv
// Streams binarized matrices from the source SRAM, 2x2 max-pools them and
// writes the pooled matrices plus a terminator to the destination SRAM.
module bin_maxpool_stage
    import bin_accel_pkg::*;
(
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic [ADDR_W-1:0] src_read_address,
    input  logic [DATA_W-1:0] src_read_data,
    output logic [ADDR_W-1:0] dst_write_address,
    output logic [DATA_W-1:0] dst_write_data,
    output logic              dst_write_enable
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    logic [ST_W-1:0]   state;
    logic [1:0]        hdr_phase;
    logic [3:0]        width;
    logic [3:0]        pair_cnt;
    logic [DATA_W-1:0] row_a;
    logic [ADDR_W-1:0] dst_ptr;

    logic [3:0]        pair_total;
    logic              last_pair;
    logic [DATA_W-1:0] pooled;

    assign pair_total = width >> 1;
    assign last_pair  = (pair_cnt + 4'd1) == pair_total;

    bin_pool_row u_pool (
        .row_a  (row_a),
        .row_b  (src_read_data),
        .width  (width),
        .pooled (pooled)
    );

    // Control FSM; the source address runs one word ahead of the data it latches
    // but never past the next header, and every write output is registered.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state             <= ST_IDLE;
            hdr_phase         <= HDR_ADDR;
            width             <= '0;
            pair_cnt          <= '0;
            row_a             <= '0;
            dst_ptr           <= '0;
            dut_busy          <= 1'b0;
            src_read_address  <= '0;
            dst_write_address <= '0;
            dst_write_data    <= '0;
            dst_write_enable  <= 1'b0;
        end else begin
            dst_write_enable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dut_run) begin
                        state            <= ST_HDR;
                        hdr_phase        <= HDR_ADDR;
                        dut_busy         <= 1'b1;
                        src_read_address <= '0;
                        dst_ptr          <= '0;
                    end
                end
                ST_HDR: begin
                    case (hdr_phase)
                        HDR_ADDR: begin
                            hdr_phase <= HDR_DECODE;
                        end
                        HDR_DECODE: begin
                            if (is_legal_width(src_read_data)) begin
                                width            <= src_read_data[3:0];
                                pair_cnt         <= '0;
                                src_read_address <= src_read_address + ADDR_ONE;
                                hdr_phase        <= HDR_FILL;
                            end else begin
                                state             <= ST_TERM;
                                dst_write_enable  <= 1'b1;
                                dst_write_address <= dst_ptr;
                                dst_write_data    <= TERM_WORD;
                                dst_ptr           <= dst_ptr + ADDR_ONE;
                            end
                        end
                        HDR_FILL: begin
                            state             <= ST_ROWA;
                            hdr_phase         <= HDR_ADDR;
                            src_read_address  <= src_read_address + ADDR_ONE;
                            dst_write_enable  <= 1'b1;
                            dst_write_address <= dst_ptr;
                            dst_write_data    <= {{(DATA_W-4){1'b0}}, pair_total};
                            dst_ptr           <= dst_ptr + ADDR_ONE;
                        end
                        default: begin
                            hdr_phase <= HDR_ADDR;
                        end
                    endcase
                end
                ST_ROWA: begin
                    row_a            <= src_read_data;
                    src_read_address <= src_read_address + ADDR_ONE;
                    state            <= ST_ROWB;
                end
                ST_ROWB: begin
                    dst_write_enable  <= 1'b1;
                    dst_write_address <= dst_ptr;
                    dst_write_data    <= pooled;
                    dst_ptr           <= dst_ptr + ADDR_ONE;
                    if (last_pair) begin
                        state     <= ST_HDR;
                        hdr_phase <= HDR_ADDR;
                    end else begin
                        src_read_address <= src_read_address + ADDR_ONE;
                        pair_cnt         <= pair_cnt + 4'd1;
                        state            <= ST_ROWA;
                    end
                end
                ST_TERM: begin
                    state            <= ST_DONE;
                    src_read_address <= '0;
                end
                ST_DONE: begin
                    dut_busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_maxpool_stage.sv
// Directed self-checking bench for bin_maxpool_stage with behavioural source and destination SRAMs.
module tb_bin_maxpool_stage;
    import bin_accel_pkg::*;

    logic              clk = 1'b0;
    logic              reset_b;
    logic              dut_run;
    logic              dut_busy;
    logic [ADDR_W-1:0] src_read_address;
    logic [DATA_W-1:0] src_read_data;
    logic [ADDR_W-1:0] dst_write_address;
    logic [DATA_W-1:0] dst_write_data;
    logic              dst_write_enable;

    logic [15:0] src_mem [0:255];
    logic [15:0] dst_mem [0:255];
    logic [15:0] exp_img [0:63];
    int          exp_len;
    int          wr_count;
    logic        clear_dst;
    int          checks;
    int          failures;
    int          sp;
    int          dp;
    int          max_addr;

    bin_maxpool_stage dut (
        .clk               (clk),
        .reset_b           (reset_b),
        .dut_run           (dut_run),
        .dut_busy          (dut_busy),
        .src_read_address  (src_read_address),
        .src_read_data     (src_read_data),
        .dst_write_address (dst_write_address),
        .dst_write_data    (dst_write_data),
        .dst_write_enable  (dst_write_enable)
    );

    always #5 clk = ~clk;

    // Source SRAM with one cycle of read latency.
    always @(posedge clk) begin
        src_read_data <= src_mem[src_read_address[7:0]];
    end

    // Destination SRAM plus write counter; cleared to a poison value on request.
    always @(posedge clk) begin
        if (clear_dst) begin
            for (int i = 0; i < 256; i++) dst_mem[i] <= 16'hDEAD;
            wr_count <= 0;
        end else if (dst_write_enable) begin
            dst_mem[dst_write_address[7:0]] <= dst_write_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] refPool(input logic [15:0] a, input logic [15:0] b, input int w);
        logic [15:0] both;
        logic [15:0] res;
        both = a | b;
        res  = '0;
        for (int j = 0; j < w / 2; j++) begin
            res[j] = ((both >> (2 * j)) & 16'h0003) != 16'h0000;
        end
        return res;
    endfunction

    task automatic clearSrc();
        for (int i = 0; i < 256; i++) src_mem[i] = 16'h0000;
        sp = 0;
        dp = 0;
        exp_len = 0;
    endtask

    task automatic clearDst();
        @(negedge clk) clear_dst = 1'b1;
        @(negedge clk) clear_dst = 1'b0;
    endtask

    // mode 0: zero rows, 1: all-ones rows, 2: random rows
    task automatic addMatrix(input int w, input int mode);
        logic [15:0] a;
        logic [15:0] b;
        src_mem[sp] = 16'(w);
        sp++;
        exp_img[dp] = 16'(w / 2);
        dp++;
        for (int k = 0; k < w / 2; k++) begin
            a = (mode == 0) ? 16'h0000 : (mode == 1) ? 16'hFFFF : 16'($urandom);
            b = (mode == 0) ? 16'h0000 : (mode == 1) ? 16'hFFFF : 16'($urandom);
            src_mem[sp]     = a;
            src_mem[sp + 1] = b;
            sp += 2;
            exp_img[dp] = refPool(a, b, w);
            dp++;
        end
    endtask

    task automatic finishStream(input logic [15:0] hdr);
        src_mem[sp] = hdr;
        exp_img[dp] = TERM_WORD;
        exp_len = dp + 1;
    endtask

    task automatic loadSmall8();
        clearSrc();
        addMatrix(8, 0);
        src_mem[2] = 16'h0003;
        src_mem[7] = 16'h0080;
        finishStream(TERM_WORD);
        exp_img[0] = 16'd4;
        exp_img[1] = 16'h0001;
        exp_img[2] = 16'h0000;
        exp_img[3] = 16'h0000;
        exp_img[4] = 16'h0008;
        exp_img[5] = 16'h00FF;
    endtask

    task automatic applyStimulus(input string tag, input int bound);
        int cycles;
        @(negedge clk) dut_run = 1'b1;
        @(negedge clk) dut_run = 1'b0;
        checkOutput({tag, "_busy_start"}, dut_busy, 1);
        cycles   = 0;
        max_addr = 0;
        while (dut_busy === 1'b1 && cycles < bound + 8) begin
            if (int'(src_read_address) > max_addr) max_addr = int'(src_read_address);
            cycles++;
            @(negedge clk);
        end
        checkOutput({tag, "_busy_done"}, dut_busy, 0);
        checkOutput({tag, "_busy_bound"}, 32'(cycles <= bound), 1);
        checkOutput({tag, "_src_home"}, src_read_address, 0);
        checkOutput({tag, "_we_idle"}, dst_write_enable, 0);
    endtask

    task automatic checkImage(input string tag);
        for (int i = 0; i < exp_len; i++) begin
            checkOutput($sformatf("%s_dst[%0d]", tag, i), dst_mem[i], exp_img[i]);
        end
        checkOutput({tag, "_writes"}, wr_count, exp_len);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic found;
        checks    = 0;
        failures  = 0;
        reset_b   = 1'b0;
        dut_run   = 1'b0;
        clear_dst = 1'b0;
        clearSrc();
        clearDst();
        repeat (2) @(negedge clk);

        checkOutput("rst_busy", dut_busy, 0);
        checkOutput("rst_src_addr", src_read_address, 0);
        checkOutput("rst_dst_addr", dst_write_address, 0);
        checkOutput("rst_dst_data", dst_write_data, 0);
        checkOutput("rst_we", dst_write_enable, 0);
        @(negedge clk) reset_b = 1'b1;

        // Empty stream
        clearSrc();
        finishStream(TERM_WORD);
        clearDst();
        applyStimulus("empty", 6);
        checkImage("empty");
        checkOutput("empty_max_src", max_addr, 0);

        // Single 8x8 matrix with two set rows
        loadSmall8();
        clearDst();
        applyStimulus("m8", 2 * 10 + 4);
        checkImage("m8");

        // Width masking with W=10, all-ones rows
        clearSrc();
        addMatrix(10, 1);
        finishStream(TERM_WORD);
        exp_img[0] = 16'd5;
        for (int i = 1; i <= 5; i++) exp_img[i] = 16'h001F;
        exp_img[6] = 16'h00FF;
        clearDst();
        applyStimulus("m10", 2 * 12 + 4);
        checkImage("m10");

        // Back-to-back W=14 then W=8 with random rows
        clearSrc();
        addMatrix(14, 2);
        addMatrix(8, 2);
        finishStream(TERM_WORD);
        clearDst();
        applyStimulus("b2b", 2 * 25 + 4);
        checkImage("b2b");
        checkOutput("b2b_hdr0", dst_mem[0], 16'd7);
        checkOutput("b2b_hdr8", dst_mem[8], 16'd4);
        checkOutput("b2b_term13", dst_mem[13], 16'h00FF);

        // Illegal header 12 after one W=8 matrix
        clearSrc();
        addMatrix(8, 2);
        finishStream(16'd12);
        clearDst();
        applyStimulus("illegal", 2 * 10 + 4);
        checkImage("illegal");
        checkOutput("illegal_max_src", max_addr, 9);

        // Reset during the third pooled write, then rerun
        loadSmall8();
        clearDst();
        @(negedge clk) dut_run = 1'b1;
        @(negedge clk) dut_run = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (dst_write_enable === 1'b1 && dst_write_address == 3) found = 1'b1;
            else @(negedge clk);
        end
        checkOutput("rst_mid_reach", found, 1);
        reset_b = 1'b0;
        #1;
        checkOutput("rst_mid_busy", dut_busy, 0);
        checkOutput("rst_mid_src_addr", src_read_address, 0);
        checkOutput("rst_mid_dst_addr", dst_write_address, 0);
        checkOutput("rst_mid_dst_data", dst_write_data, 0);
        checkOutput("rst_mid_we", dst_write_enable, 0);
        @(negedge clk);
        checkOutput("rst_mid_no_write", dst_mem[3], 16'hDEAD);
        checkOutput("rst_mid_prior_write", dst_mem[1], 16'h0001);
        reset_b = 1'b1;
        clearDst();
        applyStimulus("rerun", 2 * 10 + 4);
        checkImage("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
